// File: rtl/riscv_irq_gateway.sv
// Local interrupt gateway: per-source edge/level conditioning and masking,
// fixed or round-robin arbitration, and a claim/complete handshake with the core.
module riscv_irq_gateway #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [NUM_SRC-1:0] cfg_wdata_i,
    output logic [NUM_SRC-1:0] cfg_rdata_o,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               claim_i,
    input  logic               complete_i,
    input  logic [ID_W-1:0]    complete_id_i,
    output logic               busy_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_EDGE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_MODE    = 2'd3;

    logic [1:0]         state_q;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] src_q;
    logic               rr_q;
    logic [ID_W-1:0]    last_grant_q;

    logic [NUM_SRC-1:0] in_service_mask;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] rise;
    logic [ID_W-1:0]    winner;
    logic               found;

    assign busy_o = (state_q == SERVICE);

    always_comb begin
        in_service_mask = '0;
        if (state_q == SERVICE)
            in_service_mask[irq_id_o] = 1'b1;
    end

    assign eligible = pending_q & enable_q & ~in_service_mask;

    // Clears land before the new edge is OR-ed in, so a simultaneous edge wins.
    always_comb begin
        w1c       = '0;
        claim_clr = '0;
        if (cfg_we_i && cfg_addr_i == ADDR_PENDING)
            w1c = cfg_wdata_i;
        if (state_q == REQ && claim_i)
            claim_clr[irq_id_o] = 1'b1;
        rise      = src_i & ~src_q;
        pending_d = (edge_q & ((pending_q & ~w1c & ~claim_clr) | rise))
                  | (~edge_q & src_i);
    end

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = rr_q ? ((int'(last_grant_q) + 1 + k) % NUM_SRC) : k;
            if (!found && eligible[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (cfg_addr_i)
            ADDR_ENABLE:  cfg_rdata_o = enable_q;
            ADDR_EDGE:    cfg_rdata_o = edge_q;
            ADDR_PENDING: cfg_rdata_o = pending_q;
            default:      cfg_rdata_o = {{(NUM_SRC-1){1'b0}}, rr_q};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            enable_q  <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            src_q     <= '0;
            rr_q      <= 1'b0;
        end else begin
            src_q     <= src_i;
            pending_q <= pending_d;
            if (cfg_we_i) begin
                case (cfg_addr_i)
                    ADDR_ENABLE: enable_q <= cfg_wdata_i;
                    ADDR_EDGE:   edge_q   <= cfg_wdata_i;
                    ADDR_MODE:   rr_q     <= cfg_wdata_i[0];
                    default:     ;
                endcase
            end
        end
    end

    // irq_id_o stays frozen through REQ and SERVICE; only IDLE picks a new winner.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            irq_o        <= 1'b0;
            irq_id_o     <= '0;
            last_grant_q <= ID_W'(NUM_SRC - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        irq_id_o <= winner;
                        irq_o    <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (claim_i) begin
                        irq_o        <= 1'b0;
                        last_grant_q <= irq_id_o;
                        state_q      <= SERVICE;
                    end else if (!eligible[irq_id_o]) begin
                        irq_o   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SERVICE: begin
                    if (complete_i && complete_id_i == irq_id_o)
                        state_q <= IDLE;
                end
                default: begin
                    irq_o   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_irq_gateway.sv
// Directed bench for riscv_irq_gateway: drives config, source lines and the
// claim/complete handshake, comparing outputs against hand-derived values.
module tb_riscv_irq_gateway;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] src_i;
    logic       cfg_we_i;
    logic [1:0] cfg_addr_i;
    logic [7:0] cfg_wdata_i;
    logic [7:0] cfg_rdata_o;
    logic       irq_o;
    logic [2:0] irq_id_o;
    logic       claim_i;
    logic       complete_i;
    logic [2:0] complete_id_i;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    riscv_irq_gateway #(.NUM_SRC(8), .ID_W(3)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .src_i         (src_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_wdata_i   (cfg_wdata_i),
        .cfg_rdata_o   (cfg_rdata_o),
        .irq_o         (irq_o),
        .irq_id_o      (irq_id_o),
        .claim_i       (claim_i),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        tick(1);
        cfg_we_i    = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [1:0] addr, input logic [7:0] expected);
        cfg_addr_i = addr;
        #1;
        checkOutput(tag, cfg_rdata_o, expected);
    endtask

    task automatic claimIrq();
        claim_i = 1'b1;
        tick(1);
        claim_i = 1'b0;
    endtask

    task automatic completeIrq(input logic [2:0] id);
        complete_i    = 1'b1;
        complete_id_i = id;
        tick(1);
        complete_i    = 1'b0;
    endtask

    task automatic waitIrq(input string tag, input logic [2:0] exp_id);
        int n = 0;
        while (!irq_o && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_irq"}, irq_o, 1);
        checkOutput({tag, "_id"}, irq_id_o, exp_id);
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [2:0] rr_ids [4];
        rr_ids = '{3'd0, 3'd3, 3'd6, 3'd0};

        src_i = '0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
        claim_i = 1'b0; complete_i = 1'b0; complete_id_i = '0;
        tick(1);
        doReset();
        checkOutput("rst_irq", irq_o, 0);
        checkOutput("rst_id", irq_id_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        readCheck("rst_enable", 2'd0, 8'h00);
        readCheck("rst_pending", 2'd2, 8'h00);
        readCheck("rst_mode", 2'd3, 8'h00);

        // Edge source 2: single pulse, request two clocks later
        applyStimulus(2'd0, 8'h04);
        applyStimulus(2'd1, 8'h04);
        src_i = 8'h04;
        tick(1);
        src_i = 8'h00;
        checkOutput("e2_irq_early", irq_o, 0);
        readCheck("e2_pending_set", 2'd2, 8'h04);
        tick(1);
        checkOutput("e2_irq", irq_o, 1);
        checkOutput("e2_id", irq_id_o, 2);
        claimIrq();
        checkOutput("e2_busy", busy_o, 1);
        checkOutput("e2_irq_claimed", irq_o, 0);
        readCheck("e2_pending_clr", 2'd2, 8'h00);
        completeIrq(3'd2);
        checkOutput("e2_done_busy", busy_o, 0);
        tick(1);
        checkOutput("e2_no_rerequest", irq_o, 0);

        // Fixed priority between level sources 1 and 5
        applyStimulus(2'd0, 8'h22);
        applyStimulus(2'd1, 8'h00);
        src_i = 8'h22;
        tick(2);
        checkOutput("fx_irq", irq_o, 1);
        checkOutput("fx_id_first", irq_id_o, 1);
        claimIrq();
        src_i = 8'h20;
        tick(1);
        completeIrq(3'd1);
        checkOutput("fx_gap_irq", irq_o, 0);
        tick(1);
        checkOutput("fx_irq2", irq_o, 1);
        checkOutput("fx_id_second", irq_id_o, 5);
        src_i = 8'h00;
        claimIrq();
        completeIrq(3'd5);
        tick(1);
        checkOutput("fx_idle", irq_o, 0);

        // Round-robin over level sources 0, 3, 6
        doReset();
        applyStimulus(2'd3, 8'h01);
        readCheck("rr_mode", 2'd3, 8'h01);
        applyStimulus(2'd0, 8'h49);
        src_i = 8'h49;
        for (int r = 0; r < 4; r++) begin
            waitIrq($sformatf("rr%0d", r), rr_ids[r]);
            claimIrq();
            if (r == 3) src_i = 8'h00;
            completeIrq(rr_ids[r]);
        end
        tick(2);
        checkOutput("rr_idle", irq_o, 0);

        // Level source 4 retracts when it drops before claim
        applyStimulus(2'd0, 8'h10);
        src_i = 8'h10;
        waitIrq("lv", 3'd4);
        src_i = 8'h00;
        tick(2);
        checkOutput("lv_retract_irq", irq_o, 0);
        checkOutput("lv_retract_busy", busy_o, 0);
        src_i = 8'h10;
        waitIrq("lv2", 3'd4);
        src_i = 8'h00;
        claimIrq();
        checkOutput("lv_claim_wins", busy_o, 1);
        completeIrq(3'd4);
        checkOutput("lv_done", busy_o, 0);

        // Edge source 3 in service: wrong complete id, repeated edge held off
        applyStimulus(2'd0, 8'h08);
        applyStimulus(2'd1, 8'h08);
        src_i = 8'h08;
        tick(1);
        src_i = 8'h00;
        waitIrq("s3", 3'd3);
        claimIrq();
        completeIrq(3'd5);
        checkOutput("s3_bad_complete", busy_o, 1);
        src_i = 8'h08;
        tick(1);
        src_i = 8'h00;
        tick(1);
        readCheck("s3_pending_again", 2'd2, 8'h08);
        checkOutput("s3_no_irq", irq_o, 0);
        completeIrq(3'd3);
        checkOutput("s3_done", busy_o, 0);
        tick(1);
        checkOutput("s3_rereq", irq_o, 1);
        checkOutput("s3_rereq_id", irq_id_o, 3);

        // Reset during service drops everything
        claimIrq();
        checkOutput("s3_in_service", busy_o, 1);
        doReset();
        checkOutput("mid_rst_irq", irq_o, 0);
        checkOutput("mid_rst_busy", busy_o, 0);
        checkOutput("mid_rst_id", irq_id_o, 0);
        readCheck("mid_rst_pending", 2'd2, 8'h00);

        // Write-1-clear alone, then colliding with a new edge
        applyStimulus(2'd1, 8'h04);
        src_i = 8'h04;
        tick(1);
        src_i = 8'h00;
        readCheck("w1c_set", 2'd2, 8'h04);
        applyStimulus(2'd2, 8'h04);
        readCheck("w1c_clear", 2'd2, 8'h00);
        src_i = 8'h04;
        applyStimulus(2'd2, 8'h04);
        src_i = 8'h00;
        readCheck("w1c_edge_wins", 2'd2, 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
